imm_decode_buffer: RTL

//  Parametrised, buffered immediate generator for the ID stage. Decodes every RV32I/RV64I

---
 rtl/imm_gen_pkg.sv | 21 ++
 rtl/imm_decode_comb.sv | 77 +++++++
 rtl/imm_decode_buffer.sv | 89 ++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types for the ID-stage immediate generator: format codes reported alongside each
// decoded immediate, and a helper for the shift-amount width.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_ISH  = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6,
    FMT_CSR  = 3'd7
  } fmt_t;

  // RV64 widens the shift amount to 6 bits; RV32 keeps 5.
  function automatic int shamt_width(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Purely combinational RV32I/RV64I immediate decoder: maps one instruction word to its
// sign/zero-extended immediate and format code at XLEN bits.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit ENABLE_CSR = 1'b0
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt
);

  localparam int SHAMT_W = shamt_width(XLEN);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    // NOTE: defaults first so every path assigns imm/fmt and no latch is inferred.
    imm = '0;
    fmt = FMT_NONE;
    case (opcode)
      OPC_OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt = FMT_ISH;
          imm = XLEN'(inst[20 +: SHAMT_W]);
        end else begin
          fmt = FMT_I;
          imm = XLEN'($signed(inst[31:20]));
        end
      end
      OPC_LOAD, OPC_JALR: begin
        fmt = FMT_I;
        imm = XLEN'($signed(inst[31:20]));
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'($signed({inst[31:12], 12'b0}));
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      OPC_SYSTEM: begin
        // CSR address in [11:0], 5-bit zimm in [16:12]; ECALL/EBREAK carry no immediate.
        if (ENABLE_CSR && funct3 != 3'b000) begin
          fmt = FMT_CSR;
          imm = XLEN'({inst[19:15], inst[31:20]});
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_decode_buffer.sv
// Buffered immediate generator: decodes on the input side, then stores results in a
// 2-entry in-order skid buffer so IF/ID and ID/EX stalls are decoupled.
module imm_decode_buffer
  import imm_gen_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 32,
  parameter bit ENABLE_CSR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output fmt_t             out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_t             fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t          mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;
  logic            push;
  logic            pop;

  imm_decode_comb #(
    .XLEN       (XLEN),
    .ENABLE_CSR (ENABLE_CSR)
  ) u_decode (
    .inst (in_inst),
    .imm  (dec_imm),
    .fmt  (dec_fmt)
  );

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_imm = mem[rd_ptr].imm;
  assign out_fmt = mem[rd_ptr].fmt;
  assign out_tag = mem[rd_ptr].tag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      // NOTE: the two entries are reset because out_* read the head slot directly and must
      // show zero/FMT_NONE out of reset; a larger array would gate the outputs instead.
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '{imm: '0, fmt: FMT_NONE, tag: '0};
      end
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      if (push) begin
        mem[wr_ptr] <= '{imm: dec_imm, fmt: dec_fmt, tag: in_tag};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule
